execute_cycle: RTL and testbench
================================

// Module: execute_cycle
// PURPOSE
//  - EX stage of the 5-stage RV32I pipeline, directly downstream of the ID/EX register.
//  - Consumes the ID/EX outputs and selects operands using internal forwarding from MEM and WB.
//  - Performs the ALU op, computes the branch target and PCSrcE, then registers results into EX/MEM.
//  - PCSrcE/PCTargetE feed the fetch stage; EX/MEM outputs feed the memory stage.
// PARAMETERS
//  - XLEN    32  datapath width (operands, PC, results)
//  - FWD_EN  1   1: MEM/WB forwarding enabled; 0: operands always RD1_E/RD2_E
// PORTS
//  - clk         in   1     clock, rising edge
//  - rst         in   1     asynchronous, active-low reset
//  - RegWriteE   in   1     ID/EX register-write enable
//  - ALUSrcE     in   1     1: SrcB = Imm_Ext_E; 0: SrcB = forwarded RS2 value
//  - MemWriteE   in   1     ID/EX store enable
//  - ResultSrcE  in   1     1: WB takes memory read data; 0: ALU result
//  - BranchE     in   1     instruction is beq
//  - ALUControlE in   3     ALU op (encoding below)
//  - RD1_E       in   XLEN  RS1 register-file value
//  - RD2_E       in   XLEN  RS2 register-file value
//  - Imm_Ext_E   in   XLEN  sign-extended immediate
//  - RS1_E       in   5     source register 1 index
//  - RS2_E       in   5     source register 2 index
//  - RD_E        in   5     destination register index
//  - PCE         in   XLEN  PC of the EX instruction
//  - PCPlus4E    in   XLEN  PCE + 4
//  - ResultW     in   XLEN  WB-stage result (forwarding source)
//  - RegWriteW   in   1     WB-stage write enable
//  - RDW         in   5     WB-stage destination index
//  - PCSrcE      out  1     combinational: take branch (BranchE & ZeroE)
//  - PCTargetE   out  XLEN  combinational: PCE + Imm_Ext_E, modulo 2^XLEN
//  - RegWriteM   out  1     EX/MEM register
//  - MemWriteM   out  1     EX/MEM register
//  - ResultSrcM  out  1     EX/MEM register
//  - RD_M        out  5     EX/MEM register
//  - ALUResultM  out  XLEN  EX/MEM register; also the MEM forwarding source
//  - WriteDataM  out  XLEN  EX/MEM register: forwarded RS2 value (store data)
//  - PCPlus4M    out  XLEN  EX/MEM register
// BEHAVIOUR
//  - Reset: rst low asynchronously clears every EX/MEM output to 0, independent of clk.
//    Deassertion is synchronous to the next clk edge.
//    After reset, the MEM stage holds a bubble (RegWriteM = 0, MemWriteM = 0).
//  - Latency: EX/MEM outputs update 1 cycle after inputs are presented.
//    No stall or handshake; the register loads on every rising clk edge when rst is high.
//  - Forwarding for SrcA (RS1_E), first match wins:
//    - RegWriteM && RD_M != 0 && RD_M == RS1_E: use ALUResultM.
//    - else RegWriteW && RDW != 0 && RDW == RS1_E: use ResultW.
//    - else: use RD1_E.
//    - SrcB-pre (RS2_E) uses the same rule. With FWD_EN = 0, always RD1_E/RD2_E.
//    - MEM has priority over WB when both match (newest value wins).
//    - x0 is never forwarded.
//  - SrcB = ALUSrcE ? Imm_Ext_E : SrcB-pre. WriteDataM captures SrcB-pre, never the immediate.
//  - ALUControlE encoding:
//    - 000 add; 001 sub; 010 and; 011 or
//    - 101 slt: signed compare, result 1 or 0 zero-extended
//    - other codes: result 0
//    - add/sub wrap modulo 2^XLEN; no overflow flag.
//  - ZeroE = (ALU result == 0).
//  - Loads forward ALUResultM (the address) if followed immediately. The hazard unit must stall for load-use.
//  - Reset mid-operation: the in-flight EX/MEM content is discarded. PCSrcE stays combinational from inputs.
// TESTING
//  - Reset: rst = 0 mid-cycle with RegWriteE = 1 -> all *M outputs 0 immediately, before the next clk edge.
//  - add/sub wrap: RD1_E = 0xFFFFFFFF, RD2_E = 1, ALUSrcE = 0, op 000 -> ALUResultM = 0 next cycle.
//    Same operands, op 001 -> 0xFFFFFFFE.
//  - Forward priority: RS1_E = 5, RD_M = 5 and RDW = 5, both writing, ALUResultM = 0x10, ResultW = 0x20, op add, SrcB = 0
//    -> ALUResultM = 0x10.
//  - x0 guard: RS2_E = 0, RD_M = 0, RegWriteM = 1, ALUResultM = 0x55, RD2_E = 0 -> WriteDataM = 0, not 0x55.
//  - Branch: BranchE = 1, op 001, RD1_E = RD2_E = 7, PCE = 0x100, Imm = 0xFFFFFFF8 -> PCSrcE = 1, PCTargetE = 0xF8.
//    With RD2_E = 8 -> PCSrcE = 0.
//  - slt signed: RD1_E = 0x80000000, Imm = 1, ALUSrcE = 1, op 101 -> ALUResultM = 1.

Source files
------------

// File: rtl/execute_cycle.sv
// ---------------------------------------------------------------------------
// execute_cycle
//
// EX stage of the 5-stage RV32I pipeline. It sits directly behind the ID/EX
// register and does the following:
//   - Selects the ALU operands. RS1/RS2 values can be forwarded from the MEM
//     stage (this block's own EX/MEM register) or from the WB stage.
//   - Runs the ALU.
//   - Works out the beq decision (PCSrcE) and the branch target (PCTargetE).
//     Both go straight to fetch.
//   - Registers everything the MEM stage needs into the EX/MEM register.
//
// Ports
//   clk, rst         rising-edge clock; asynchronous active-low reset
//   RegWriteE ..     ID/EX control: register write, SrcB select, store
//                    enable, WB result select, beq flag, 3-bit ALU op
//   RD1_E, RD2_E     register-file values for RS1_E / RS2_E
//   Imm_Ext_E        sign-extended immediate
//   RS1_E, RS2_E     source register indices; RD_E is the destination index
//   PCE, PCPlus4E    PC of this instruction and PC + 4
//   ResultW, RegWriteW, RDW   WB-stage forwarding source
//   PCSrcE, PCTargetE         combinational branch decision and target
//   *M outputs       EX/MEM register contents; ALUResultM is also the MEM
//                    forwarding source
// ---------------------------------------------------------------------------
module execute_cycle #(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [4:0]      RS1_E,
  input  logic [4:0]      RS2_E,
  input  logic [4:0]      RD_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] ResultW,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b_pre;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic            fwd_m_a;
  logic            fwd_w_a;
  logic            fwd_m_b;
  logic            fwd_w_b;

  // Forwarding match terms. A producer that targets x0 never forwards,
  // because x0 always reads as zero no matter what was "written" to it.
  assign fwd_m_a = FWD_EN && RegWriteM && (RD_M != 5'd0) && (RD_M == RS1_E);
  assign fwd_w_a = FWD_EN && RegWriteW && (RDW  != 5'd0) && (RDW  == RS1_E);
  assign fwd_m_b = FWD_EN && RegWriteM && (RD_M != 5'd0) && (RD_M == RS2_E);
  assign fwd_w_b = FWD_EN && RegWriteW && (RDW  != 5'd0) && (RDW  == RS2_E);

  // Operand selection. MEM is checked first because it holds the newer
  // value when both MEM and WB target the same register. For a load in MEM,
  // ALUResultM is the address, not the data. The hazard unit has to stall
  // load-use pairs so that this case never reaches here.
  always_comb begin
    src_a = RD1_E;
    if (fwd_m_a)      src_a = ALUResultM;
    else if (fwd_w_a) src_a = ResultW;

    src_b_pre = RD2_E;
    if (fwd_m_b)      src_b_pre = ALUResultM;
    else if (fwd_w_b) src_b_pre = ResultW;
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : src_b_pre;

  // ALU. Add and sub wrap naturally at XLEN bits. Any unassigned op code
  // produces zero.
  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero      = (alu_result == '0);
  assign PCSrcE    = BranchE & zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  // EX/MEM register. Reset empties the MEM stage to a bubble and drops
  // whatever instruction was in flight. WriteDataM keeps the forwarded RS2
  // value even when the ALU took the immediate, since that value is the
  // store data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      RD_M       <= 5'd0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RD_M       <= RD_E;
      ALUResultM <= alu_result;
      WriteDataM <= src_b_pre;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// ---------------------------------------------------------------------------
// tb_execute_cycle
//
// Directed bench for execute_cycle. Each task drives one scenario and checks
// the results against values worked out by hand. The tasks run in sequence
// from a single initial block.
// ---------------------------------------------------------------------------
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteE;
  logic        ALUSrcE;
  logic        MemWriteE;
  logic        ResultSrcE;
  logic        BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] Imm_Ext_E;
  logic [4:0]  RS1_E;
  logic [4:0]  RS2_E;
  logic [4:0]  RD_E;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [31:0] ResultW;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;

  int checks   = 0;
  int failures = 0;

  execute_cycle #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteE   (RegWriteE),
    .ALUSrcE     (ALUSrcE),
    .MemWriteE   (MemWriteE),
    .ResultSrcE  (ResultSrcE),
    .BranchE     (BranchE),
    .ALUControlE (ALUControlE),
    .RD1_E       (RD1_E),
    .RD2_E       (RD2_E),
    .Imm_Ext_E   (Imm_Ext_E),
    .RS1_E       (RS1_E),
    .RS2_E       (RS2_E),
    .RD_E        (RD_E),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .ResultW     (ResultW),
    .RegWriteW   (RegWriteW),
    .RDW         (RDW),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .PCPlus4M    (PCPlus4M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Puts every input into a neutral state: no writes, no forwarding
  // sources, register x0 everywhere.
  task automatic clear_inputs();
    RegWriteE   = 1'b0;
    ALUSrcE     = 1'b0;
    MemWriteE   = 1'b0;
    ResultSrcE  = 1'b0;
    BranchE     = 1'b0;
    ALUControlE = 3'b000;
    RD1_E       = 32'h0;
    RD2_E       = 32'h0;
    Imm_Ext_E   = 32'h0;
    RS1_E       = 5'd0;
    RS2_E       = 5'd0;
    RD_E        = 5'd0;
    PCE         = 32'h0;
    PCPlus4E    = 32'h0;
    ResultW     = 32'h0;
    RegWriteW   = 1'b0;
    RDW         = 5'd0;
  endtask

  // Advances one rising edge, then waits 1 time unit so that outputs are
  // read away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if ({RegWriteM, MemWriteM, ResultSrcM} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b exp=000", {RegWriteM, MemWriteM, ResultSrcM});
    end
    checks++;
    if ({RD_M, ALUResultM, WriteDataM, PCPlus4M} !== 101'd0) begin
      failures++;
      $display("[TB] FAIL reset_data got rd=%h alu=%h wd=%h pc4=%h exp=0", RD_M, ALUResultM, WriteDataM, PCPlus4M);
    end
    @(negedge clk);
    rst = 1'b1;

    // Put a real instruction into EX/MEM, then drop reset mid-cycle
    RegWriteE  = 1'b1;
    MemWriteE  = 1'b1;
    ResultSrcE = 1'b1;
    RD_E       = 5'd7;
    RD1_E      = 32'h0000_0011;
    RD2_E      = 32'h0000_0022;
    PCPlus4E   = 32'h0000_0044;
    step();
    checks++;
    if ({RegWriteM, RD_M, ALUResultM} !== {1'b1, 5'd7, 32'h33}) begin
      failures++;
      $display("[TB] FAIL preload got rw=%b rd=%0d alu=%h exp rw=1 rd=7 alu=33", RegWriteM, RD_M, ALUResultM);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M} !== 104'd0) begin
      failures++;
      $display("[TB] FAIL async_reset got rw=%b mw=%b rs=%b rd=%0d alu=%h wd=%h pc4=%h exp all 0",
               RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M);
    end
    step();
    checks++;
    if ({RegWriteM, MemWriteM, ALUResultM} !== 34'd0) begin
      failures++;
      $display("[TB] FAIL reset_hold got rw=%b mw=%b alu=%h exp 0", RegWriteM, MemWriteM, ALUResultM);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
  endtask

  task automatic test_add_sub_wrap();
    clear_inputs();
    RD1_E       = 32'hFFFF_FFFF;
    RD2_E       = 32'h0000_0001;
    ALUControlE = 3'b000;
    step();
    checks++;
    if (ALUResultM !== 32'h0) begin
      failures++;
      $display("[TB] FAIL add_wrap got=%h exp=00000000", ALUResultM);
    end
    ALUControlE = 3'b001;
    step();
    checks++;
    if (ALUResultM !== 32'hFFFF_FFFE) begin
      failures++;
      $display("[TB] FAIL sub got=%h exp=fffffffe", ALUResultM);
    end
  endtask

  task automatic test_logic_ops();
    clear_inputs();
    RD1_E       = 32'h0000_F0F0;
    RD2_E       = 32'h0000_0FF0;
    ALUControlE = 3'b010;
    step();
    checks++;
    if (ALUResultM !== 32'h0000_00F0) begin
      failures++;
      $display("[TB] FAIL and got=%h exp=000000f0", ALUResultM);
    end
    ALUControlE = 3'b011;
    step();
    checks++;
    if (ALUResultM !== 32'h0000_FFF0) begin
      failures++;
      $display("[TB] FAIL or got=%h exp=0000fff0", ALUResultM);
    end
    ALUControlE = 3'b100;
    step();
    checks++;
    if (ALUResultM !== 32'h0) begin
      failures++;
      $display("[TB] FAIL unused_op got=%h exp=00000000", ALUResultM);
    end
  endtask

  task automatic test_slt();
    clear_inputs();
    RD1_E       = 32'h8000_0000;
    Imm_Ext_E   = 32'h0000_0001;
    ALUSrcE     = 1'b1;
    ALUControlE = 3'b101;
    step();
    checks++;
    if (ALUResultM !== 32'h1) begin
      failures++;
      $display("[TB] FAIL slt_neg got=%h exp=00000001", ALUResultM);
    end
    RD1_E     = 32'h0000_0005;
    Imm_Ext_E = 32'h0000_0003;
    step();
    checks++;
    if (ALUResultM !== 32'h0) begin
      failures++;
      $display("[TB] FAIL slt_pos got=%h exp=00000000", ALUResultM);
    end
  endtask

  task automatic test_store();
    clear_inputs();
    MemWriteE   = 1'b1;
    ResultSrcE  = 1'b1;
    RD_E        = 5'd9;
    RD1_E       = 32'h0000_1000;
    Imm_Ext_E   = 32'h0000_0008;
    ALUSrcE     = 1'b1;
    RD2_E       = 32'h0000_ABCD;
    PCPlus4E    = 32'h0000_0204;
    step();
    checks++;
    if ({RegWriteM, MemWriteM, ResultSrcM, RD_M} !== {3'b011, 5'd9}) begin
      failures++;
      $display("[TB] FAIL store_ctrl got rw=%b mw=%b rs=%b rd=%0d exp rw=0 mw=1 rs=1 rd=9",
               RegWriteM, MemWriteM, ResultSrcM, RD_M);
    end
    checks++;
    if ({ALUResultM, WriteDataM, PCPlus4M} !== {32'h1008, 32'hABCD, 32'h204}) begin
      failures++;
      $display("[TB] FAIL store_data got alu=%h wd=%h pc4=%h exp alu=00001008 wd=0000abcd pc4=00000204",
               ALUResultM, WriteDataM, PCPlus4M);
    end
  endtask

  task automatic test_back_to_back();
    // Producer: x5 = 0x10
    clear_inputs();
    RegWriteE = 1'b1;
    RD_E      = 5'd5;
    RD1_E     = 32'h0000_0010;
    step();
    // Consumer of x5 while WB also writes x5 (older, 0x20): MEM must win
    RS1_E     = 5'd5;
    RD1_E     = 32'h0000_0099;
    RD_E      = 5'd6;
    RegWriteW = 1'b1;
    RDW       = 5'd5;
    ResultW   = 32'h0000_0020;
    step();
    checks++;
    if (ALUResultM !== 32'h10) begin
      failures++;
      $display("[TB] FAIL fwd_priority got=%h exp=00000010", ALUResultM);
    end
    // Now MEM holds x6 = 0x10; RS1 = x5 only matches WB, RS2 = x6 matches MEM
    RS2_E = 5'd6;
    RD2_E = 32'h0000_0077;
    RD_E  = 5'd8;
    step();
    checks++;
    if (ALUResultM !== 32'h30) begin
      failures++;
      $display("[TB] FAIL fwd_wb_and_mem got=%h exp=00000030", ALUResultM);
    end
    checks++;
    if (WriteDataM !== 32'h10) begin
      failures++;
      $display("[TB] FAIL fwd_store_data got=%h exp=00000010", WriteDataM);
    end
  endtask

  task automatic test_x0_guard();
    // Producer that "writes" x0 with 0x55
    clear_inputs();
    RegWriteE = 1'b1;
    RD_E      = 5'd0;
    RD1_E     = 32'h0000_0055;
    step();
    checks++;
    if ({RegWriteM, RD_M, ALUResultM} !== {1'b1, 5'd0, 32'h55}) begin
      failures++;
      $display("[TB] FAIL x0_setup got rw=%b rd=%0d alu=%h exp rw=1 rd=0 alu=00000055", RegWriteM, RD_M, ALUResultM);
    end
    RD1_E     = 32'h0;
    RegWriteW = 1'b1;
    RDW       = 5'd0;
    ResultW   = 32'h0000_0077;
    step();
    checks++;
    if (WriteDataM !== 32'h0) begin
      failures++;
      $display("[TB] FAIL x0_guard_wd got=%h exp=00000000", WriteDataM);
    end
    checks++;
    if (ALUResultM !== 32'h0) begin
      failures++;
      $display("[TB] FAIL x0_guard_alu got=%h exp=00000000", ALUResultM);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    BranchE     = 1'b1;
    ALUControlE = 3'b001;
    RD1_E       = 32'h0000_0007;
    RD2_E       = 32'h0000_0007;
    PCE         = 32'h0000_0100;
    Imm_Ext_E   = 32'hFFFF_FFF8;
    #1;
    checks++;
    if ({PCSrcE, PCTargetE} !== {1'b1, 32'h0000_00F8}) begin
      failures++;
      $display("[TB] FAIL branch_taken got src=%b tgt=%h exp src=1 tgt=000000f8", PCSrcE, PCTargetE);
    end
    RD2_E = 32'h0000_0008;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin
      failures++;
      $display("[TB] FAIL branch_not_taken got=%b exp=0", PCSrcE);
    end
    // Equal operands but no beq: no redirect
    RD2_E   = 32'h0000_0007;
    BranchE = 1'b0;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin
      failures++;
      $display("[TB] FAIL branch_disabled got=%b exp=0", PCSrcE);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_add_sub_wrap();
    test_logic_ops();
    test_slt();
    test_store();
    test_back_to_back();
    test_x0_guard();
    test_branch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
